// File: rtl/gate_actuator_pkg.sv
// Shared definitions for the barrier gate actuator: state encoding,
// default travel parameters and a small state classification helper.
package gate_actuator_pkg;

  // Default maximum motor-on cycles per stroke before declaring a fault.
  localparam int TRAVEL_MAX_DEF = 50;
  // Default travel counter width.
  localparam int CNT_W_DEF      = 8;

  // One-hot barrier states. 6'd32 is reserved; any value outside the
  // listed encodings is treated as illegal and recovers to ST_CLOSED.
  typedef enum logic [5:0] {
    ST_CLOSED  = 6'd1,
    ST_OPENING = 6'd2,
    ST_OPEN    = 6'd4,
    ST_CLOSING = 6'd8,
    ST_FAULT   = 6'd16
  } gate_state_e;

  // True for the states in which the motor is driving the barrier.
  function automatic logic state_is_stroke(input gate_state_e s);
    return (s == ST_OPENING) || (s == ST_CLOSING);
  endfunction

  // True for legal states that are subject to the limit-switch conflict check.
  function automatic logic state_is_supervised(input gate_state_e s);
    return (s == ST_CLOSED) || (s == ST_OPENING) ||
           (s == ST_OPEN)   || (s == ST_CLOSING);
  endfunction

endpackage

// File: rtl/gate_actuator_if.sv
// Signal bundle between the entry controller / field sensors and the
// barrier actuator. master = controller and sensor side, slave = actuator.
interface gate_actuator_if;

  logic gate_o;          // open command level
  logic gate_cls;        // close command (level or pulse)
  logic alm_blkg;        // blocking alarm, inhibits or aborts closing
  logic lim_open;        // fully-open limit switch
  logic lim_closed;      // fully-closed limit switch
  logic obstr;           // obstruction beam blocked
  logic fault_clr;       // operator fault acknowledge
  logic motor_up;        // drive barrier upward
  logic motor_dn;        // drive barrier downward
  logic gate_is_open;    // barrier resting open
  logic gate_is_closed;  // barrier resting closed
  logic fault;           // sticky fault indication

  modport master (
    output gate_o, gate_cls, alm_blkg, lim_open, lim_closed, obstr, fault_clr,
    input  motor_up, motor_dn, gate_is_open, gate_is_closed, fault
  );

  modport slave (
    input  gate_o, gate_cls, alm_blkg, lim_open, lim_closed, obstr, fault_clr,
    output motor_up, motor_dn, gate_is_open, gate_is_closed, fault
  );

endinterface

// File: rtl/gate_actuator_travel_timer.sv
// Saturating per-stroke travel counter. Cleared at the start of every
// stroke, counts while the motor runs, and flags expiry on the last
// permitted motor-on cycle so the state machine can leave on that edge.
module gate_actuator_travel_timer #(
  parameter int CNT_W      = 8,
  parameter int TRAVEL_MAX = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TRAVEL_MAX - 1);

  logic [CNT_W-1:0] count_reg;

  // Count motor-on cycles; clear wins over enable, saturate at the last count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != LAST_COUNT)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign expire = (count_reg == LAST_COUNT);

endmodule

// File: rtl/gate_actuator.sv
// Barrier gate actuator: turns open/close commands from the entry
// controller into motor drive, closes the loop on limit switches and the
// obstruction beam, times out strokes and latches faults until acknowledged.
module gate_actuator
  import gate_actuator_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TRAVEL_MAX = TRAVEL_MAX_DEF
) (
  input  logic           clock,
  input  logic           reset,
  gate_actuator_if.slave bus
);

  gate_state_e state_reg;
  gate_state_e state_next;
  logic        timer_clr;
  logic        timer_en;
  logic        timer_expire;
  logic        limit_conflict;

  // Both limit switches active at once means a wiring or sensor failure.
  assign limit_conflict = bus.lim_open & bus.lim_closed;

  // State register; asynchronous reset parks the machine in CLOSED so the
  // motor outputs drop immediately, whatever the barrier position.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_CLOSED;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decision; the limit-conflict override is applied last so it
  // dominates every legal non-fault state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLOSED: begin
        // A close request while closed is meaningless; open always wins.
        if (bus.gate_o) begin
          state_next = ST_OPENING;
        end
      end
      ST_OPENING: begin
        // Commands are ignored mid-stroke; only the limit or timeout ends it.
        if (bus.lim_open) begin
          state_next = ST_OPEN;
        end else if (timer_expire) begin
          state_next = ST_FAULT;
        end
      end
      ST_OPEN: begin
        // A close request that cannot be honoured now is dropped, not queued.
        if (bus.gate_cls && !bus.gate_o && !bus.alm_blkg && !bus.obstr) begin
          state_next = ST_CLOSING;
        end
      end
      ST_CLOSING: begin
        // Reaching the closed limit beats any late reversal reason.
        if (bus.lim_closed) begin
          state_next = ST_CLOSED;
        end else if (bus.obstr || bus.gate_o || bus.alm_blkg) begin
          state_next = ST_OPENING;
        end else if (timer_expire) begin
          state_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        // Leave only on acknowledge with exactly one consistent limit switch.
        if (bus.fault_clr && bus.lim_closed && !bus.lim_open) begin
          state_next = ST_CLOSED;
        end else if (bus.fault_clr && bus.lim_open && !bus.lim_closed) begin
          state_next = ST_OPEN;
        end
      end
      default: begin
        state_next = ST_CLOSED;
      end
    endcase

    if (limit_conflict && state_is_supervised(state_reg)) begin
      state_next = ST_FAULT;
    end
  end

  // A new stroke (including a reversal) starts whenever the next state is a
  // motion state different from the current one.
  assign timer_clr = state_is_stroke(state_next) && (state_next != state_reg);
  assign timer_en  = state_is_stroke(state_reg);

  gate_actuator_travel_timer #(
    .CNT_W      (CNT_W),
    .TRAVEL_MAX (TRAVEL_MAX)
  ) u_travel_timer (
    .clock  (clock),
    .reset  (reset),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // Moore output decode; one-hot state guarantees the motors never both run.
  assign bus.motor_up       = (state_reg == ST_OPENING);
  assign bus.motor_dn       = (state_reg == ST_CLOSING);
  assign bus.gate_is_open   = (state_reg == ST_OPEN);
  assign bus.gate_is_closed = (state_reg == ST_CLOSED);
  assign bus.fault          = (state_reg == ST_FAULT);

endmodule

// File: tb/tb_gate_actuator.sv
// Directed bench for gate_actuator with TRAVEL_MAX = 8. A behavioural model
// tracks barrier mode and motor-on cycles per stroke; every cycle its
// expected outputs are compared with the DUT, and hand-computed literals
// pin stroke lengths and key scenario outcomes.
module tb_gate_actuator;

  localparam int TM = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  gate_actuator_if bus ();

  gate_actuator #(
    .CNT_W      (8),
    .TRAVEL_MAX (TM)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_CLOSED, M_OPENING, M_OPEN, M_CLOSING, M_FAULT} mode_t;
  mode_t mode      = M_CLOSED;
  int    on_cycles = 0;   // motor-on cycles elapsed in the current stroke, current one included

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode      = M_CLOSED;
      on_cycles = 0;
    end else if (mode != M_FAULT && bus.lim_open && bus.lim_closed) begin
      mode = M_FAULT;
    end else begin
      case (mode)
        M_CLOSED:
          if (bus.gate_o) begin mode = M_OPENING; on_cycles = 1; end
        M_OPENING:
          if (bus.lim_open) mode = M_OPEN;
          else if (on_cycles >= TM) mode = M_FAULT;
          else on_cycles++;
        M_OPEN:
          if (bus.gate_cls && !bus.gate_o && !bus.alm_blkg && !bus.obstr) begin
            mode = M_CLOSING; on_cycles = 1;
          end
        M_CLOSING:
          if (bus.lim_closed) mode = M_CLOSED;
          else if (bus.obstr || bus.gate_o || bus.alm_blkg) begin mode = M_OPENING; on_cycles = 1; end
          else if (on_cycles >= TM) mode = M_FAULT;
          else on_cycles++;
        default:
          if (bus.fault_clr && bus.lim_closed && !bus.lim_open) mode = M_CLOSED;
          else if (bus.fault_clr && bus.lim_open && !bus.lim_closed) mode = M_OPEN;
      endcase
    end
  end

  // ---------------- per-cycle compare and stroke-length monitor ----------------
  int up_cnt = 0;
  int dn_cnt = 0;

  always @(negedge clock) begin
    logic [4:0] exp_v;
    exp_v = {mode == M_OPENING, mode == M_CLOSING, mode == M_OPEN, mode == M_CLOSED, mode == M_FAULT};
    check("cycle_outputs",
          {27'd0, bus.motor_up, bus.motor_dn, bus.gate_is_open, bus.gate_is_closed, bus.fault},
          {27'd0, exp_v});
    if (bus.motor_up) up_cnt++;
    if (bus.motor_dn) dn_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    bus.gate_o = 0; bus.gate_cls = 0; bus.alm_blkg = 0; bus.lim_open = 0;
    bus.lim_closed = 0; bus.obstr = 0; bus.fault_clr = 0;

    // 1: reset for 3 cycles, open stroke of 5 motor cycles
    #1 reset = 0;
    tick(3);
    reset = 1;
    check("reset_closed", bus.gate_is_closed, 1);
    check("reset_motors", {bus.motor_up, bus.motor_dn, bus.fault}, 0);
    up_cnt = 0;
    bus.gate_o = 1; tick(1); bus.gate_o = 0;
    tick(4); bus.lim_open = 1; tick(1);
    check("t1_up_cycles", up_cnt, 5);
    check("t1_open", {bus.gate_is_open, bus.motor_up}, 2'b10);

    // 5a: close request blocked by alarm or obstruction is dropped
    bus.gate_cls = 1; bus.alm_blkg = 1; tick(2);
    check("t5_alarm_stays_open", {bus.gate_is_open, bus.motor_dn}, 2'b10);
    bus.alm_blkg = 0; bus.obstr = 1; tick(1);
    check("t5_obstr_stays_open", bus.gate_is_open, 1);
    bus.gate_cls = 0; bus.obstr = 0; tick(1);
    check("t5_no_queue", bus.gate_is_open, 1);

    // 2: close stroke of 4 motor cycles
    dn_cnt = 0;
    bus.gate_cls = 1; tick(1); bus.gate_cls = 0; bus.lim_open = 0;
    tick(3); bus.lim_closed = 1; tick(1);
    check("t2_dn_cycles", dn_cnt, 4);
    check("t2_closed", bus.gate_is_closed, 1);

    // 3: obstruction on 2nd closing cycle reverses with a fresh stroke timer
    bus.gate_o = 1; tick(1); bus.gate_o = 0; bus.lim_closed = 0;
    tick(2); bus.lim_open = 1; tick(1);
    check("t3_open", bus.gate_is_open, 1);
    bus.gate_cls = 1; tick(1); bus.gate_cls = 0; bus.lim_open = 0;
    tick(1); bus.obstr = 1; tick(1); bus.obstr = 0;
    check("t3_reversal", {bus.motor_up, bus.motor_dn}, 2'b10);
    up_cnt = 0;
    tick(8);
    check("t3_reversal_full_stroke", up_cnt, 8);
    check("t3_fault", bus.fault, 1);
    tick(3);
    check("t3_fault_sticky", bus.fault, 1);
    bus.fault_clr = 1; tick(1);
    check("t3_clr_no_limit", bus.fault, 1);
    bus.lim_open = 1; bus.lim_closed = 1; tick(1);
    check("t3_clr_both_limits", bus.fault, 1);
    bus.lim_open = 0; tick(1);
    check("t3_clr_to_closed", bus.gate_is_closed, 1);
    bus.fault_clr = 0;

    // 4: open with no limit switch -> exactly 8 motor cycles then fault
    bus.gate_o = 1; tick(1); bus.gate_o = 0; bus.lim_closed = 0;
    up_cnt = 0;
    tick(8);
    check("t4_up_cycles", up_cnt, 8);
    check("t4_fault", {bus.fault, bus.motor_up}, 2'b10);
    tick(2);
    check("t4_fault_sticky", bus.fault, 1);
    bus.fault_clr = 1; bus.lim_open = 1; tick(1); bus.fault_clr = 0;
    check("t4_clr_to_open", bus.gate_is_open, 1);

    // closing timeout
    bus.gate_cls = 1; tick(1); bus.gate_cls = 0; bus.lim_open = 0;
    dn_cnt = 0;
    tick(8);
    check("close_timeout_cycles", dn_cnt, 8);
    check("close_timeout_fault", bus.fault, 1);
    bus.fault_clr = 1; bus.lim_closed = 1; tick(1); bus.fault_clr = 0;
    check("close_timeout_clr", bus.gate_is_closed, 1);

    // 5b: limit conflict in CLOSED and OPENING
    bus.lim_open = 1; tick(1);
    check("t5_conflict_closed", bus.fault, 1);
    bus.lim_open = 0; bus.fault_clr = 1; tick(1); bus.fault_clr = 0;
    bus.gate_o = 1; tick(1); bus.gate_o = 0; bus.lim_closed = 0;
    check("t5_opening", bus.motor_up, 1);
    bus.lim_open = 1; bus.lim_closed = 1; tick(1);
    check("t5_conflict_opening", {bus.fault, bus.motor_up}, 2'b10);
    bus.lim_closed = 0; bus.fault_clr = 1; tick(1); bus.fault_clr = 0;
    check("t5_clr_to_open", bus.gate_is_open, 1);

    // lim_closed beats simultaneous obstruction and open command
    bus.gate_cls = 1; tick(1); bus.gate_cls = 0; bus.lim_open = 0;
    bus.lim_closed = 1; bus.obstr = 1; bus.gate_o = 1; tick(1);
    bus.obstr = 0; bus.gate_o = 0;
    check("closed_limit_wins", bus.gate_is_closed, 1);

    // alarm reversal during closing
    bus.gate_o = 1; tick(1); bus.gate_o = 0; bus.lim_closed = 0;
    bus.lim_open = 1; tick(1);
    bus.gate_cls = 1; tick(1); bus.gate_cls = 0; bus.lim_open = 0;
    bus.alm_blkg = 1; tick(1); bus.alm_blkg = 0;
    check("alarm_reversal", {bus.motor_up, bus.motor_dn}, 2'b10);
    bus.lim_open = 1; tick(1);
    check("alarm_reopened", bus.gate_is_open, 1);

    // 6: asynchronous reset during OPENING
    bus.gate_cls = 1; tick(1); bus.gate_cls = 0; bus.lim_open = 0;
    bus.lim_closed = 1; tick(1);
    bus.gate_o = 1; tick(1); bus.gate_o = 0; bus.lim_closed = 0;
    tick(2);
    check("t6_opening", bus.motor_up, 1);
    #2 reset = 0;
    #1;
    check("t6_async_motor_off", {bus.motor_up, bus.gate_is_closed}, 2'b01);
    tick(2);
    reset = 1;
    tick(1);
    check("t6_closed_after_release", bus.gate_is_closed, 1);
    bus.gate_o = 1; tick(1); bus.gate_o = 0;
    check("t6_reopen", bus.motor_up, 1);
    bus.lim_open = 1; tick(1);
    check("t6_open", bus.gate_is_open, 1);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
